algo_1r4w_wrfifo: RTL

Write-absorb FIFO for the 1r4w algorithmic memory.
- Accepts up to 4 writes per cycle, compacted in port order.
- Drains up to NUMWTPT entries per cycle toward the bank-write stage.
- Drives per-port write backpressure from a delayed occupancy compare.
- Sits between the 4 user write ports and the core write scheduler; its occupancy is the reference count the core assertions track.

---
 rtl/algo_1r4w_wrfifo_pkg.sv | 26 ++
 rtl/algo_1r4w_wrfifo_if.sv | 33 +++
 rtl/algo_1r4w_wrfifo_compact.sv | 39 +++
 rtl/algo_1r4w_wrfifo.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/algo_1r4w_wrfifo_pkg.sv
// Shared definitions for the 1r4w write-absorb FIFO.
//   NUMWRPT_DEF / NUMWTPT_DEF : default enqueue ports / dequeues per cycle
//   wr_entry_t                : {addr, data} entry for the default widths
//   popcount4                 : population count of a 4-bit mask
//   min_u                     : unsigned minimum
package algo_1r4w_pkg;

  localparam int unsigned NUMWRPT_DEF = 4;
  localparam int unsigned NUMWTPT_DEF = 2;
  localparam int unsigned WIDTH_DEF   = 32;
  localparam int unsigned BITADDR_DEF = 13;

  typedef struct packed {
    logic [BITADDR_DEF-1:0] addr;
    logic [WIDTH_DEF-1:0]   data;
  } wr_entry_t;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

  function automatic int unsigned min_u(input int unsigned a, input int unsigned b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/algo_1r4w_wrfifo_if.sv
// Write-side and drain-side handshake bundle of the write-absorb FIFO.
//   write/wr_adr/din : per-port enqueue requests (port 0 in LSBs)
//   wr_bp            : per-port backpressure
//   wt_stall         : drain inhibit from the scheduler
//   wt_vld/wt_adr/wt_din : drain slots, slot 0 = oldest
// master = user ports + scheduler, slave = the FIFO.
interface algo_1r4w_wrfifo_if
  import algo_1r4w_pkg::*;
#(
  parameter int unsigned WIDTH   = WIDTH_DEF,
  parameter int unsigned BITADDR = BITADDR_DEF,
  parameter int unsigned NUMWRPT = NUMWRPT_DEF,
  parameter int unsigned NUMWTPT = NUMWTPT_DEF
);
  logic [NUMWRPT-1:0]         write;
  logic [NUMWRPT*BITADDR-1:0] wr_adr;
  logic [NUMWRPT*WIDTH-1:0]   din;
  logic [NUMWRPT-1:0]         wr_bp;
  logic                       wt_stall;
  logic [NUMWTPT-1:0]         wt_vld;
  logic [NUMWTPT*BITADDR-1:0] wt_adr;
  logic [NUMWTPT*WIDTH-1:0]   wt_din;

  modport master (
    output write, wr_adr, din, wt_stall,
    input  wr_bp, wt_vld, wt_adr, wt_din
  );

  modport slave (
    input  write, wr_adr, din, wt_stall,
    output wr_bp, wt_vld, wt_adr, wt_din
  );
endinterface

// File: rtl/algo_1r4w_wrfifo_compact.sv
// Port-order compaction of enqueue requests.
//   write  : request mask
//   free   : number of entries available this cycle
//   accept : per-port accept; the first 'free' requesters in port order win
//   offset : slot offset from wr_ptr of each port (rank among requesters)
// Supports up to 4 ports.
module algo_1r4w_wrfifo_compact
  import algo_1r4w_pkg::*;
#(
  parameter int unsigned NUMWRPT = NUMWRPT_DEF,
  parameter int unsigned FREEW   = 10
) (
  input  logic [NUMWRPT-1:0]      write,
  input  logic [FREEW-1:0]        free,
  output logic [NUMWRPT-1:0]      accept,
  output logic [NUMWRPT-1:0][1:0] offset
);

  logic [3:0] wpad;
  logic [3:0] low_mask;
  logic [2:0] rank;

  assign wpad = 4'(write);

  always_comb begin
    accept   = '0;
    offset   = '0;
    low_mask = '0;
    rank     = '0;
    for (int i = 0; i < NUMWRPT; i++) begin
      low_mask  = 4'((5'd1 << i) - 5'd1);
      rank      = popcount4(wpad & low_mask);
      // Every lower requester is accepted whenever this one is, so rank is the slot.
      offset[i] = rank[1:0];
      accept[i] = write[i] && (FREEW'(rank) < free);
    end
  end

endmodule

// File: rtl/algo_1r4w_wrfifo.sv
// Write-absorb FIFO for the 1r4w algorithmic memory.
//   clk, rst : clock, asynchronous active-high reset
//   ready    : core ready; low clears the FIFO (overflow flag holds)
//   bp_thr   : backpressure threshold on delayed occupancy
//   fifo_cnt : registered occupancy
//   fifo_ovf : sticky overflow flag, cleared only by rst
//   bus      : enqueue ports, backpressure and drain slots
// Up to NUMWRPT writes per cycle are compacted in port order; up to NUMWTPT
// oldest entries drain per cycle. Writes are drainable the cycle after.
module algo_1r4w_wrfifo
  import algo_1r4w_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned BITADDR = 13,
  parameter int unsigned NUMWRPT = NUMWRPT_DEF,
  parameter int unsigned NUMWTPT = NUMWTPT_DEF,
  parameter int unsigned BITFIFO = 8,
  parameter int unsigned BPDELAY = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ready,
  input  logic [BITFIFO:0]   bp_thr,
  output logic [BITFIFO:0]   fifo_cnt,
  output logic               fifo_ovf,
  algo_1r4w_wrfifo_if.slave  bus
);

  localparam int unsigned DEPTH = 2 ** BITFIFO;
  localparam int unsigned CNTW  = BITFIFO + 1;
  localparam int unsigned CW    = BITFIFO + 2;

  logic [CNTW-1:0]    cnt_q, cnt_d;
  logic [BITFIFO-1:0] wr_ptr_q, rd_ptr_q;
  logic               ovf_q, ovf_set;
  logic               bp_q;
  logic [CNTW-1:0]    bp_cnt;

  logic [BITADDR-1:0] mem_adr [DEPTH];
  logic [WIDTH-1:0]   mem_din [DEPTH];

  logic [CW-1:0]             dcnt, free, acnt;
  logic [NUMWRPT-1:0]        wr_req, accept;
  logic [NUMWRPT-1:0][1:0]   offset;

  logic [BITFIFO-1:0]         ridx;
  logic [NUMWTPT-1:0]         vld;
  logic [NUMWTPT*BITADDR-1:0] dadr;
  logic [NUMWTPT*WIDTH-1:0]   ddin;

  // Dequeue frees space in the same cycle, so it counts toward free.
  always_comb begin
    dcnt   = bus.wt_stall ? '0 : CW'(min_u(32'(cnt_q), NUMWTPT));
    free   = CW'(DEPTH) - CW'(cnt_q) + dcnt;
    wr_req = ready ? bus.write : '0;
  end

  algo_1r4w_wrfifo_compact #(
    .NUMWRPT (NUMWRPT),
    .FREEW   (CW)
  ) u_compact (
    .write  (wr_req),
    .free   (free),
    .accept (accept),
    .offset (offset)
  );

  always_comb begin
    acnt = '0;
    for (int i = 0; i < NUMWRPT; i++) begin
      acnt = acnt + CW'(accept[i]);
    end
    cnt_d   = CNTW'(CW'(cnt_q) + acnt - dcnt);
    ovf_set = |(wr_req & ~accept);
  end

  // Drain slots read storage directly; same-cycle writes are never visible.
  always_comb begin
    ridx = '0;
    vld  = '0;
    dadr = '0;
    ddin = '0;
    for (int k = 0; k < NUMWTPT; k++) begin
      ridx   = rd_ptr_q + BITFIFO'(k);
      vld[k] = !bus.wt_stall && (int'(cnt_q) > k);
      dadr[k*BITADDR +: BITADDR] = mem_adr[ridx];
      ddin[k*WIDTH +: WIDTH]     = mem_din[ridx];
    end
  end

  assign bus.wt_vld = vld;
  assign bus.wt_adr = dadr;
  assign bus.wt_din = ddin;
  assign bus.wr_bp  = {NUMWRPT{bp_q}};
  assign fifo_cnt   = cnt_q;
  assign fifo_ovf   = ovf_q;

  // wr_bp itself is the last stage, so BPDELAY-1 extra stages precede it.
  if (BPDELAY <= 1) begin : g_bp_direct
    assign bp_cnt = cnt_q;
  end else begin : g_bp_line
    logic [CNTW-1:0] line_q [BPDELAY-1];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < BPDELAY - 1; i++) line_q[i] <= '0;
      end else if (!ready) begin
        for (int i = 0; i < BPDELAY - 1; i++) line_q[i] <= '0;
      end else begin
        line_q[0] <= cnt_q;
        for (int i = 1; i < BPDELAY - 1; i++) line_q[i] <= line_q[i-1];
      end
    end

    assign bp_cnt = line_q[BPDELAY-2];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
      bp_q     <= 1'b0;
    end else if (!ready) begin
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      bp_q     <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_q + BITFIFO'(acnt);
      rd_ptr_q <= rd_ptr_q + BITFIFO'(dcnt);
      ovf_q    <= ovf_q | ovf_set;
      bp_q     <= (bp_cnt > bp_thr);
    end
  end

  // Storage is not reset; accept is already gated by ready.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUMWRPT; i++) begin
      if (accept[i]) begin
        mem_adr[wr_ptr_q + BITFIFO'(offset[i])] <= bus.wr_adr[i*BITADDR +: BITADDR];
        mem_din[wr_ptr_q + BITFIFO'(offset[i])] <= bus.din[i*WIDTH +: WIDTH];
      end
    end
  end

endmodule
